// File: rtl/sgbm_pkg.sv
// Shared types and widths for the stereo grey-pixel stream blocks.
//   PIX_W   : grey pixel width
//   COORD_W : row/column tag width
//   state_t : receiver sequencing state
//   coord_t : packed (row, col) pair
package sgbm_pkg;
  localparam int PIX_W   = 8;
  localparam int COORD_W = 10;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } coord_t;
endpackage

// File: rtl/sgbm_stream_rx_if.sv
// Stereo pixel stream in, vertical pixel columns out.
//   master : pixel source / column sink (drives grey_*, valid)
//   slave  : sgbm_stream_rx (drives col_*, out_*, frame_done, seq_err)
interface sgbm_stream_rx_if #(parameter int WIN = 3);
  import sgbm_pkg::*;

  logic [PIX_W-1:0]     grey_left, grey_right;
  logic [COORD_W-1:0]   grey_row_left, grey_col_left;
  logic [COORD_W-1:0]   grey_row_right, grey_col_right;
  logic                 valid;
  logic [PIX_W*WIN-1:0] col_left, col_right;
  logic [COORD_W-1:0]   out_row, out_col;
  logic                 out_valid, frame_done, seq_err;

  modport master (
    output grey_left, grey_right, grey_row_left, grey_col_left,
           grey_row_right, grey_col_right, valid,
    input  col_left, col_right, out_row, out_col, out_valid, frame_done, seq_err
  );

  modport slave (
    input  grey_left, grey_right, grey_row_left, grey_col_left,
           grey_row_right, grey_col_right, valid,
    output col_left, col_right, out_row, out_col, out_valid, frame_done, seq_err
  );
endinterface

// File: rtl/sgbm_line_shift.sv
// Per-column shift line memory for one eye: WIN-1 lines of IMAGE_COL pixels.
// A write at column addr pushes din into line 0 and ages lines 0..WIN-3 down
// by one. The column output is combinational and uses pre-write contents:
//   column = {din, line[0][addr], ..., line[WIN-2][addr]} (line[WIN-2] in LSBs)
// Ports: clk, we (write/shift enable), addr (column), din (new pixel), column.
module sgbm_line_shift import sgbm_pkg::*; #(
  parameter int WIN       = 3,
  parameter int IMAGE_COL = 400,
  parameter int AW        = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [PIX_W-1:0]     din,
  output logic [PIX_W*WIN-1:0] column
);
  // Not reset: stale lines are never emitted because output is gated by row.
  logic [PIX_W-1:0] line [0:WIN-2][0:IMAGE_COL-1];

  always_ff @(posedge clk) begin
    if (we) begin
      line[0][addr] <= din;
      for (int k = 1; k < WIN-1; k++) line[k][addr] <= line[k-1][addr];
    end
  end

  always_comb begin
    column = '0;
    column[PIX_W*(WIN-1) +: PIX_W] = din;
    for (int k = 0; k < WIN-1; k++)
      column[PIX_W*(WIN-2-k) +: PIX_W] = line[k][addr];
  end
endmodule

// File: rtl/sgbm_stream_rx.sv
// Stereo grey-pixel stream receiver. Checks raster order and left/right tag
// agreement, keeps WIN-1 lines per eye and, for each accepted pixel at row
// >= WIN-1, emits a WIN-tall column per eye one cycle later.
// Ports: clk, rst (async, active high), bus (slave modport: pixel stream in,
// col_left/col_right/out_row/out_col/out_valid/frame_done/seq_err out).
module sgbm_stream_rx import sgbm_pkg::*; #(
  parameter int IMAGE_ROW = 200,
  parameter int IMAGE_COL = 400,
  parameter int WIN       = 3
) (
  input  logic             clk,
  input  logic             rst,
  sgbm_stream_rx_if.slave  bus
);
  localparam int AW = (IMAGE_COL > 1) ? $clog2(IMAGE_COL) : 1;
  localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(IMAGE_ROW-1);
  localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(IMAGE_COL-1);
  localparam logic [COORD_W-1:0] FIRST_OUT = COORD_W'(WIN-1);

  state_t state, state_nxt;
  coord_t exp_q, exp_nxt, pix, pix_inc;
  logic   consistent, at_exp, at_origin, at_last;
  logic   accept, done, err;

  logic [1:0][PIX_W-1:0]     din;
  logic [1:0][PIX_W*WIN-1:0] col_w;

  assign pix        = {bus.grey_row_left, bus.grey_col_left};
  assign consistent = bus.valid && (bus.grey_row_left == bus.grey_row_right)
                                && (bus.grey_col_left == bus.grey_col_right);
  assign at_exp     = consistent && (pix == exp_q);
  assign at_origin  = consistent && (pix == '0);
  assign at_last    = (pix.row == LAST_ROW) && (pix.col == LAST_COL);
  assign pix_inc    = (pix.col == LAST_COL) ? {pix.row + 1'b1, {COORD_W{1'b0}}}
                                            : {pix.row, pix.col + 1'b1};

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_q;
    accept    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (bus.valid) begin
      unique case (state)
        IDLE: if (at_origin) begin
          accept    = 1'b1;
          state_nxt = RUN;
          exp_nxt   = pix_inc;
        end
        RUN: if (at_exp) begin
          accept = 1'b1;
          if (at_last) begin
            done      = 1'b1;
            state_nxt = IDLE;
            exp_nxt   = '0;
          end else begin
            exp_nxt = pix_inc;
          end
        end else begin
          err = 1'b1;
          // A clean (0,0) mid-frame restarts the frame instead of dropping it.
          if (at_origin) begin
            accept  = 1'b1;
            exp_nxt = pix_inc;
          end else begin
            state_nxt = IDLE;
            exp_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Eye 0 = left, eye 1 = right.
  assign din = {bus.grey_right, bus.grey_left};

  for (genvar e = 0; e < 2; e++) begin : g_eye
    sgbm_line_shift #(.WIN(WIN), .IMAGE_COL(IMAGE_COL), .AW(AW)) u_line (
      .clk    (clk),
      .we     (accept),
      .addr   (pix.col[AW-1:0]),
      .din    (din[e]),
      .column (col_w[e])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      exp_q          <= '0;
      bus.col_left   <= '0;
      bus.col_right  <= '0;
      bus.out_row    <= '0;
      bus.out_col    <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.seq_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      exp_q          <= exp_nxt;
      bus.seq_err    <= bus.seq_err | err;
      bus.frame_done <= done;
      bus.out_valid  <= accept && (pix.row >= FIRST_OUT);
      if (accept && (pix.row >= FIRST_OUT)) begin
        bus.col_left  <= col_w[0];
        bus.col_right <= col_w[1];
        bus.out_row   <= pix.row;
        bus.out_col   <= pix.col;
      end
    end
  end
endmodule

// File: tb/tb_sgbm_stream_rx.sv
module tb_sgbm_stream_rx;
  import sgbm_pkg::*;

  localparam int ROWS = 4, COLS = 5, WIN = 3, CW = PIX_W*WIN, NPIX = ROWS*COLS;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  sgbm_stream_rx_if #(.WIN(WIN)) bus();

  sgbm_stream_rx #(.IMAGE_ROW(ROWS), .IMAGE_COL(COLS), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [CW-1:0] cl, cr;
    int            row, col;
    bit            fd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] hist_l [COLS][$];
  logic [7:0] hist_r [COLS][$];
  int         m_next;          // raster index expected next; 0 means waiting for a frame
  bit         m_err;
  int         m_fd, mon_fd;
  int         checks, failures;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Newest WIN pixels seen at a column, oldest in the LSBs.
  function automatic logic [CW-1:0] window(input logic [7:0] h[$]);
    logic [CW-1:0] w = '0;
    for (int k = 0; k < WIN; k++) w[8*k +: 8] = h[h.size()-WIN+k];
    return w;
  endfunction

  task automatic model_step(int rl, int cl, int rr, int cr, logic [7:0] pl, logic [7:0] pr);
    bit cons = (rl == rr) && (cl == cr);
    bit hit  = cons && rl < ROWS && cl < COLS && (rl*COLS + cl == m_next);
    bit acc  = 1'b0, fd = 1'b0;
    exp_t e;
    if (hit) begin
      acc    = 1'b1;
      m_next = rl*COLS + cl + 1;
      if (m_next == NPIX) begin fd = 1'b1; m_next = 0; m_fd++; end
    end else if (m_next != 0) begin
      m_err = 1'b1;
      if (cons && rl == 0 && cl == 0) begin acc = 1'b1; m_next = 1; end
      else m_next = 0;
    end
    if (acc) begin
      hist_l[cl].push_back(pl);
      hist_r[cl].push_back(pr);
      while (hist_l[cl].size() > WIN) void'(hist_l[cl].pop_front());
      while (hist_r[cl].size() > WIN) void'(hist_r[cl].pop_front());
      if (rl >= WIN-1) begin
        e.cl = window(hist_l[cl]); e.cr = window(hist_r[cl]);
        e.row = rl; e.col = cl; e.fd = fd;
        sb.push_back(e);
      end
    end
  endtask

  task automatic send(int rl, int cl, int rr, int cr, logic [7:0] pl, logic [7:0] pr);
    bus.grey_left = pl; bus.grey_right = pr;
    bus.grey_row_left  = COORD_W'(rl); bus.grey_col_left  = COORD_W'(cl);
    bus.grey_row_right = COORD_W'(rr); bus.grey_col_right = COORD_W'(cr);
    bus.valid = 1'b1;
    model_step(rl, cl, rr, cr, pl, pr);
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pixels(int from, int to, int maxgap);
    for (int i = from; i <= to; i++) begin
      int r = i / COLS, c = i % COLS;
      send(r, c, r, c, 8'(16*r + c), 8'(16*r + c + 1));
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    chk("sb_empty_before_rst", 64'(sb.size()), 64'd0);
    rst = 1'b1; m_next = 0; m_err = 1'b0;
    #1;
    chk("rst_col_left",   64'(bus.col_left),   64'd0);
    chk("rst_col_right",  64'(bus.col_right),  64'd0);
    chk("rst_out_row",    64'(bus.out_row),    64'd0);
    chk("rst_out_col",    64'(bus.out_col),    64'd0);
    chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
    chk("rst_seq_err",    64'(bus.seq_err),    64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic random_phase(int n);
    int src = 0;
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(0, 19);
      int r, c, rr, cr;
      if (k == 0) src = (src + 1) % NPIX;   // skip one position
      if (k == 2) src = 0;                  // premature restart
      r = src / COLS; c = src % COLS; rr = r; cr = c;
      if (k == 1) rr = (r + 1) % ROWS;      // left/right disagreement
      send(r, c, rr, cr, 8'($urandom), 8'($urandom));
      src = (src + 1) % NPIX;
      idle($urandom_range(0, 2));
    end
  endtask

  // Monitor: every presented column is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.out_valid || bus.frame_done)) begin
        if (bus.frame_done) mon_fd++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got row %0d col %0d, expected no output",
                   bus.out_row, bus.out_col);
        end else begin
          e = sb.pop_front();
          chk("out_valid",  64'(bus.out_valid),  64'd1);
          chk("col_left",   64'(bus.col_left),   64'(e.cl));
          chk("col_right",  64'(bus.col_right),  64'(e.cr));
          chk("out_row",    64'(bus.out_row),    64'(e.row));
          chk("out_col",    64'(bus.out_col),    64'(e.col));
          chk("frame_done", 64'(bus.frame_done), 64'(e.fd));
        end
      end
    end
  end

  initial begin
    bus.valid = 1'b0; bus.grey_left = '0; bus.grey_right = '0;
    bus.grey_row_left = '0; bus.grey_col_left = '0;
    bus.grey_row_right = '0; bus.grey_col_right = '0;
    checks = 0; failures = 0; m_next = 0; m_err = 1'b0; m_fd = 0; mon_fd = 0;
    do_reset();

    // Continuous frame, then check held outputs after the last column.
    pixels(0, NPIX-1, 0);
    idle(2);
    chk("s1_seq_err",   64'(bus.seq_err),   64'd0);
    chk("s1_hold_cl",   64'(bus.col_left),  64'h342414);
    chk("s1_hold_cr",   64'(bus.col_right), 64'h352515);
    chk("s1_hold_row",  64'(bus.out_row),   64'd3);
    chk("s1_hold_col",  64'(bus.out_col),   64'd4);
    chk("s1_hold_vld",  64'(bus.out_valid), 64'd0);
    chk("s1_fd_count",  64'(mon_fd),        64'd1);

    // Same frame with random gaps.
    pixels(0, NPIX-1, 3);
    idle(2);
    chk("s2_seq_err", 64'(bus.seq_err), 64'd0);

    // Skip (1,2) -> (1,4): error, drop, idle until the next (0,0).
    pixels(0, 6, 0);
    send(1, 4, 1, 4, 8'h14, 8'h15);
    chk("s3_seq_err", 64'(bus.seq_err), 64'd1);
    chk("s3_state",   64'(dut.state),   64'(IDLE));
    pixels(10, NPIX-1, 0);
    chk("s3_dropped", 64'(sb.size()),   64'd0);
    pixels(0, NPIX-1, 0);
    idle(2);
    chk("s3_sticky",  64'(bus.seq_err), 64'd1);

    // Left/right row disagreement at (0,3).
    do_reset();
    pixels(0, 2, 0);
    send(0, 3, 1, 3, 8'h03, 8'h04);
    chk("s4_seq_err", 64'(bus.seq_err), 64'd1);
    chk("s4_state",   64'(dut.state),   64'(IDLE));

    // Reset while a row-2 column is being presented.
    do_reset();
    pixels(0, 12, 0);
    chk("s5_vld_before_rst", 64'(bus.out_valid), 64'd1);
    do_reset();
    pixels(0, NPIX-1, 0);
    idle(2);
    chk("s5_seq_err", 64'(bus.seq_err), 64'd0);

    // Back-to-back frames.
    pixels(0, NPIX-1, 0);
    pixels(0, NPIX-1, 0);
    idle(2);
    chk("s6_seq_err", 64'(bus.seq_err), 64'd0);

    // Randomized traffic with random data and occasional sequence faults.
    random_phase(400);
    idle(3);
    chk("rand_seq_err", 64'(bus.seq_err),   64'(m_err));
    chk("final_sb",     64'(sb.size()),     64'd0);
    chk("final_fd",     64'(mon_fd),        64'(m_fd));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
